// File: rtl/handshake_rr_arbiter_pkg.sv
// handshake_rr_arbiter_pkg: state encodings and counter width shared by the arbiter files.
package handshake_rr_arbiter_pkg;
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;
    localparam int ARB_CNT_W = 32;
endpackage

// File: rtl/handshake_rr_arbiter_rr_pick.sv
// rr_pick: rotate-priority encoder, first set request at or after ptr (wrapping).
module rr_pick
    import handshake_rr_arbiter_pkg::*;
#(
    parameter int n  = 4,
    parameter int iw = $clog2(n)
) (
    input  logic [n-1:0]  req,
    input  logic [iw-1:0] ptr,
    output logic [iw-1:0] grant,
    output logic          any
);
    logic [iw:0]   sum;
    logic [iw-1:0] idx;
    // Scan farthest offset first so the nearest request to ptr is the last to win.
    always_comb begin
        grant = ptr;
        any = |req;
        sum = '0;
        idx = '0;
        for (int k = n - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (iw + 1)'(k);
            idx = iw'(sum >= (iw + 1)'(n) ? sum - (iw + 1)'(n) : sum);
            if (req[idx]) grant = idx;
        end
    end
endmodule

// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter: round-robin sharing of one req/ack producer among num_req consumers.
// Define ARB_STATS_EN to add the per-requester grant_count outputs.
module handshake_rr_arbiter
    import handshake_rr_arbiter_pkg::*;
#(
    parameter int num_req    = 4,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [num_req-1:0]    req_in,
    output logic [num_req-1:0]    ack_out,
    output logic [data_width-1:0] dout,
    output logic                  req_out,
    input  logic                  ack_in,
    input  logic [data_width-1:0] din
`ifdef ARB_STATS_EN
    ,
    output logic [ARB_CNT_W*num_req-1:0] grant_count
`endif
);
    localparam int iw = $clog2(num_req);

    arb_state_t    state;
    logic [iw-1:0] ptr, grant, pick;
    logic          any;

    rr_pick #(.n(num_req), .iw(iw)) u_pick (
        .req  (req_in),
        .ptr  (ptr),
        .grant(pick),
        .any  (any)
    );

    // Once granted, the transaction runs to completion regardless of req_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            req_out <= 1'b0;
            ack_out <= '0;
            dout    <= '0;
            ptr     <= '0;
            grant   <= '0;
        end else begin
            case (state)
                ARB_IDLE: if (any) begin
                    grant   <= pick;
                    req_out <= 1'b1;
                    state   <= ARB_WAIT;
                end
                ARB_WAIT: if (ack_in) begin
                    dout           <= din;
                    ack_out[grant] <= 1'b1;
                    req_out        <= 1'b0;
                    ptr            <= (grant == iw'(num_req - 1)) ? '0 : grant + iw'(1);
                    state          <= ARB_DONE;
                end
                default: begin
                    ack_out <= '0;
                    state   <= ARB_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            grant_count <= '0;
        else if (state == ARB_WAIT && ack_in)
            for (int i = 0; i < num_req; i++)
                if (grant == iw'(i))
                    grant_count[ARB_CNT_W*i +: ARB_CNT_W] <= grant_count[ARB_CNT_W*i +: ARB_CNT_W] + ARB_CNT_W'(1);
    end
`endif
endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// tb_handshake_rr_arbiter: directed tests with a transaction-level reference model.
module tb_handshake_rr_arbiter;
    localparam int n = 4;
    localparam int w = 32;

    logic         clk = 0, rst = 1;
    logic [n-1:0] req_in = '0, ack_out;
    logic [w-1:0] dout, din = '0;
    logic         req_out, ack_in = 0;
`ifdef ARB_STATS_EN
    logic [32*n-1:0] grant_count;
`endif
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    handshake_rr_arbiter #(.num_req(n), .data_width(w)) dut (
        .clk    (clk),
        .rst    (rst),
        .req_in (req_in),
        .ack_out(ack_out),
        .dout   (dout),
        .req_out(req_out),
        .ack_in (ack_in),
        .din    (din)
`ifdef ARB_STATS_EN
        ,
        .grant_count(grant_count)
`endif
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a transaction is free, asking the producer, or cooling down.
    int           m_phase = 0, m_owner = 0, m_ptr = 0;
    logic         m_req_out = 0;
    logic [n-1:0] m_ack = '0;
    logic [w-1:0] m_dout = '0;
    int unsigned  m_cnt[n];

    function automatic int rr(logic [n-1:0] r, int p);
        for (int k = 0; k < n; k++)
            if (r[(p + k) % n]) return (p + k) % n;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_req_out = 0; m_ack = '0; m_dout = '0; m_ptr = 0; m_owner = 0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else begin
            m_ack = '0;
            if (m_phase == 0 && req_in != 0) begin
                m_owner = rr(req_in, m_ptr);
                m_req_out = 1;
                m_phase = 1;
            end else if (m_phase == 1 && ack_in) begin
                m_dout = din;
                m_ack[m_owner] = 1'b1;
                m_req_out = 0;
                m_ptr = (m_owner + 1) % n;
                m_cnt[m_owner]++;
                m_phase = 2;
            end else if (m_phase == 2) begin
                m_phase = 0;
            end
        end
    end

    typedef struct {int idx; logic [31:0] data; int t;} ev_t;
    ev_t log_q[$];
    int  cyc_n = 0, rq_hi = 0;
    bit  chk_on = 0;

    always @(negedge clk) begin
        cyc_n++;
        if (chk_on) begin
            chk("ack_out", 64'(ack_out), 64'(m_ack));
            chk("dout", 64'(dout), 64'(m_dout));
            chk("req_out", 64'(req_out), 64'(m_req_out));
`ifdef ARB_STATS_EN
            for (int i = 0; i < n; i++)
                chk("grant_count", 64'(grant_count[32*i +: 32]), 64'(m_cnt[i]));
`endif
            if (req_out) rq_hi++;
            if (ack_out != 0) log_q.push_back('{$clog2(ack_out), dout, cyc_n});
        end
    end

    // Producer: acks one cycle after seeing req_out, optionally failing at random.
    int          fail_rate = 0;
    bit          prod_auto = 1, prev = 0;
    logic [31:0] word = 0;

    initial forever begin
        @(negedge clk);
        #1;
        if (prod_auto) begin
            if (req_out && prev && !ack_in && $urandom_range(99, 0) >= 32'(fail_rate)) begin
                ack_in = 1; din = word; word++;
            end else ack_in = 0;
            prev = req_out;
        end
    end

    task automatic tick(int k = 1);
        repeat (k) begin @(negedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1; req_in = '0; ack_in = 0;
        tick(2);
        rst = 0;
    endtask

    task automatic ack_once(logic [31:0] v);
        int b = 0;
        while (!req_out && b < 20) begin tick(); b++; end
        if (!req_out) begin
            checks++; errors++;
            $display("FAIL ack_once_timeout: req_out never rose");
        end else begin
            tick();
            ack_in = 1; din = v;
            tick();
            ack_in = 0;
        end
    endtask

    initial begin
        int base, b, bad, rst_base, sum;
        int seen[1000];
        int per[n];
        do_reset();
        chk_on = 1;
        chk("rst_ack_out", 64'(ack_out), 0);
        chk("rst_req_out", 64'(req_out), 0);
        chk("rst_dout", 64'(dout), 0);

        // Single requester: ack every 4 cycles, dout 0,1,2,3, req_out 2 cycles each.
        word = 0; rq_hi = 0; base = log_q.size(); req_in = 4'b0001; b = 0;
        while (log_q.size() < base + 4 && b < 60) begin tick(); b++; end
        req_in = '0;
        tick(3);
        chk("t1_acks", 64'(log_q.size() - base), 4);
        for (int j = 0; j < 4 && base + j < log_q.size(); j++) begin
            chk("t1_idx", 64'(log_q[base + j].idx), 0);
            chk("t1_data", 64'(log_q[base + j].data), 64'(j));
            if (j > 0) chk("t1_spacing", 64'(log_q[base + j].t - log_q[base + j - 1].t), 4);
        end
        chk("t1_req_out_cycles", 64'(rq_hi), 8);

        // All four requesting: strict rotation, 250 each, words 0..999 exactly once.
        do_reset();
        word = 0; base = log_q.size(); req_in = 4'b1111; b = 0;
        while (log_q.size() < base + 1000 && b < 5000) begin tick(); b++; end
        req_in = '0;
        tick(3);
        chk("t2_acks", 64'(log_q.size() - base), 1000);
        bad = 0;
        foreach (per[i]) per[i] = 0;
        foreach (seen[i]) seen[i] = 0;
        for (int j = base; j < log_q.size(); j++) begin
            if (log_q[j].idx != (j - base) % n) bad++;
            per[log_q[j].idx]++;
            if (log_q[j].data < 1000) seen[log_q[j].data]++;
        end
        chk("t2_order_errs", 64'(bad), 0);
        for (int i = 0; i < n; i++) chk("t2_per_requester", 64'(per[i]), 250);
        bad = 0;
        foreach (seen[i]) if (seen[i] != 1) bad++;
        chk("t2_gap_dup", 64'(bad), 0);
`ifdef ARB_STATS_EN
        for (int i = 0; i < n; i++) chk("t2_grant_count", 64'(grant_count[32*i +: 32]), 250);
`endif

        // Requester 2 drops during WAIT: still acked; next grant goes to 3.
        do_reset();
        prod_auto = 0; base = log_q.size();
        req_in = 4'b1100;
        tick();
        req_in = 4'b1000;
        ack_once(32'hABCD);
        ack_once(32'h1234);
        req_in = '0;
        tick(3);
        chk("t3_acks", 64'(log_q.size() - base), 2);
        if (log_q.size() >= base + 2) begin
            chk("t3_first_idx", 64'(log_q[base].idx), 2);
            chk("t3_first_data", 64'(log_q[base].data), 64'h0000ABCD);
            chk("t3_next_idx", 64'(log_q[base + 1].idx), 3);
            chk("t3_next_data", 64'(log_q[base + 1].data), 64'h00001234);
        end

        // Spurious ack_in while idle: no ack_out, dout keeps last word.
        base = log_q.size();
        ack_in = 1; din = 32'hDEAD;
        tick();
        ack_in = 0;
        tick(2);
        chk("t4_dout_kept", 64'(dout), 64'h00001234);
        chk("t4_no_ack", 64'(log_q.size() - base), 0);
        chk("t4_req_out", 64'(req_out), 0);

        // Reset mid-WAIT: req_out drops, in-flight ack ignored, ptr back to 0.
        do_reset();
        base = log_q.size();
        req_in = 4'b1111;
        ack_once(32'h11);
        b = 0;
        while (!req_out && b < 20) begin tick(); b++; end
        chk("t5_second_grant_waiting", 64'(req_out), 1);
        rst = 1;
        tick();
        chk("t5_rst_req_out", 64'(req_out), 0);
        chk("t5_rst_ack_out", 64'(ack_out), 0);
        rst_base = log_q.size();
        rst = 0; ack_in = 1; din = 32'hBAD; req_in = 4'b1001;
        tick();
        ack_in = 0;
        ack_once(32'h22);
        req_in = '0;
        tick(3);
        chk("t5_acks", 64'(log_q.size() - base), 2);
        if (log_q.size() >= base + 2) begin
            chk("t5_pre_idx", 64'(log_q[base].idx), 0);
            chk("t5_post_idx", 64'(log_q[base + 1].idx), 0);
            chk("t5_post_data", 64'(log_q[base + 1].data), 64'h22);
        end

        // Random requests against a flaky producer: ack totals agree with counters.
        prod_auto = 1; fail_rate = 50;
        for (int c = 0; c < 600; c++) begin
            req_in = n'($urandom);
            tick();
        end
        req_in = '0;
        b = 0;
        while (req_out && b < 200) begin tick(); b++; end
        tick(3);
        chk("t6_quiet", 64'(req_out), 0);
        sum = 0;
        foreach (m_cnt[i]) sum += int'(m_cnt[i]);
        chk("t6_ack_total", 64'(log_q.size() - rst_base), 64'(sum));
`ifdef ARB_STATS_EN
        sum = 0;
        for (int i = 0; i < n; i++) sum += int'(grant_count[32*i +: 32]);
        chk("t6_counter_sum", 64'(sum), 64'(log_q.size() - rst_base));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
